// File: rtl/sha2_stream_core.sv
// Streaming SHA-256/SHA-224 core: byte-lane message absorb, hardware padding, multi-block
// chaining, one compression round per clock, digest streamed out over valid/ready.
module sha2_stream_core #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [2:0]       in_nbytes,
  input  logic             mode_224,
  output logic             in_ready,
  output logic [OUT_W-1:0] dig_data,
  output logic             dig_valid,
  output logic             dig_last,
  input  logic             dig_ready,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Both buses: a beat transfers on the rising edge where valid & ready are both high;
  // while valid is high and ready is low the source holds data/last/nbytes stable.

  if (IN_W != 8 && IN_W != 16 && IN_W != 32) begin : g_bad_in_w
    $error("sha2_stream_core: IN_W must be 8, 16 or 32");
  end
  if (OUT_W != 8 && OUT_W != 16 && OUT_W != 32) begin : g_bad_out_w
    $error("sha2_stream_core: OUT_W must be 8, 16 or 32");
  end

  typedef enum logic [2:0] {
    ST_ABSORB   = 3'd0,
    ST_PAD      = 3'd1,
    ST_COMPRESS = 3'd2,
    ST_UPDATE   = 3'd3,
    ST_OUTPUT   = 3'd4
  } state_t;

  localparam int          IN_B     = IN_W / 8;
  localparam int          N256     = 256 / OUT_W;
  localparam int          N224     = 224 / OUT_W;
  localparam logic [5:0]  LAST256  = 6'(N256 - 1);
  localparam logic [5:0]  LAST224  = 6'(N224 - 1);
  localparam logic [31:0] IN_MASK  = ~(32'hffff_ffff >> IN_W);

  localparam logic [255:0] IV_256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV_224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t        r_state, w_next;
  logic [31:0]   r_w [16];
  logic [31:0]   w_blk [16];
  logic [31:0]   r_h [8];
  logic [31:0]   r_v [8];
  logic [6:0]    r_ptr;
  logic [63:0]   r_len;
  logic [5:0]    r_round;
  logic [5:0]    r_obeat;
  logic          r_mode;
  logic          r_busy;
  logic          r_last_seen;
  logic          r_pad_done;
  logic          r_final;

  logic          w_acc;
  logic [6:0]    w_nb;
  logic [6:0]    w_ptr_nxt;
  logic [4:0]    w_shift;
  logic [31:0]   w_ins;
  logic [31:0]   w_mask;
  logic          w_pad_final;
  logic          w_dlast;
  logic [31:0]   w_t1;
  logic [31:0]   w_t2;
  logic [31:0]   w_wnew;
  logic [255:0]  w_iv;
  logic [255:0]  w_hcat;

  assign in_ready    = (r_state == ST_ABSORB);
  assign dig_valid   = (r_state == ST_OUTPUT);
  assign busy        = r_busy;
  assign dbg_state   = r_state;
  assign w_acc       = in_valid && in_ready;
  assign w_ptr_nxt   = r_ptr + w_nb;
  assign w_pad_final = r_pad_done || (r_ptr <= 7'd55);
  assign w_iv        = mode_224 ? IV_224 : IV_256;
  assign w_hcat      = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};
  assign w_dlast     = (r_state == ST_OUTPUT) && (r_obeat == (r_mode ? LAST224 : LAST256));
  assign dig_last    = w_dlast;

  // Beats are aligned to their width, so a beat always lands inside one 32-bit word.
  assign w_shift = {r_ptr[1:0], 3'b000};
  assign w_ins   = (32'(in_data) << (32 - IN_W)) >> w_shift;
  assign w_mask  = IN_MASK >> w_shift;

  always_comb begin
    w_nb = 7'(IN_B);
    if (in_last) w_nb = (in_nbytes > 3'(IN_B)) ? 7'(IN_B) : {4'd0, in_nbytes};
  end

  assign w_t1 = r_v[7] + (rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25))
              + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + K_ROM[r_round] + r_w[0];
  assign w_t2 = (rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22))
              + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
  // r_w holds W_t..W_t+15 during compression; the tail gets W_t+16.
  assign w_wnew = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
                + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_ABSORB: begin
        if (w_acc) begin
          if (w_ptr_nxt == 7'd64) w_next = ST_COMPRESS;
          else if (in_last)       w_next = ST_PAD;
        end
      end
      ST_PAD:      w_next = ST_COMPRESS;
      ST_COMPRESS: if (r_round == 6'd63) w_next = ST_UPDATE;
      ST_UPDATE: begin
        if (r_final)          w_next = ST_OUTPUT;
        else if (r_last_seen) w_next = ST_PAD;
        else                  w_next = ST_ABSORB;
      end
      ST_OUTPUT:   if (dig_ready && w_dlast) w_next = ST_ABSORB;
      default:     w_next = ST_ABSORB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ABSORB;
    else        r_state <= w_next;
  end

  always_comb begin
    for (int i = 0; i < 16; i++) w_blk[i] = r_w[i];
    case (r_state)
      ST_ABSORB: begin
        if (w_acc) w_blk[r_ptr[5:2]] = (r_w[r_ptr[5:2]] & ~w_mask) | w_ins;
      end
      ST_PAD: begin
        // Second pass of a pad-only sequence clears everything but the length.
        for (int b = 0; b < 64; b++) begin
          if (r_pad_done || 7'(b) > r_ptr) w_blk[b/4][8*(3-b%4) +: 8] = 8'h00;
          else if (7'(b) == r_ptr)         w_blk[b/4][8*(3-b%4) +: 8] = 8'h80;
        end
        if (w_pad_final) begin
          for (int b = 56; b < 64; b++) w_blk[b/4][8*(3-b%4) +: 8] = r_len[8*(63-b) +: 8];
        end
      end
      ST_COMPRESS: begin
        for (int i = 0; i < 15; i++) w_blk[i] = r_w[i+1];
        w_blk[15] = w_wnew;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= IV_256[255-32*i -: 32];
        r_v[i] <= '0;
      end
      r_ptr       <= '0;
      r_len       <= '0;
      r_round     <= '0;
      r_obeat     <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_last_seen <= 1'b0;
      r_pad_done  <= 1'b0;
      r_final     <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) r_w[i] <= w_blk[i];
      case (r_state)
        ST_ABSORB: begin
          for (int i = 0; i < 8; i++) r_v[i] <= r_h[i];
          if (w_acc) begin
            r_ptr <= w_ptr_nxt;
            r_len <= r_len + {54'd0, w_nb, 3'd0};
            if (in_last) r_last_seen <= 1'b1;
            if (!r_busy) begin
              r_busy <= 1'b1;
              r_mode <= mode_224;
              for (int i = 0; i < 8; i++) r_h[i] <= w_iv[255-32*i -: 32];
            end
          end
        end
        ST_PAD: begin
          for (int i = 0; i < 8; i++) r_v[i] <= r_h[i];
          r_pad_done <= 1'b1;
          r_final    <= w_pad_final;
        end
        ST_COMPRESS: begin
          r_round <= r_round + 6'd1;
          r_v[0]  <= w_t1 + w_t2;
          r_v[1]  <= r_v[0];
          r_v[2]  <= r_v[1];
          r_v[3]  <= r_v[2];
          r_v[4]  <= r_v[3] + w_t1;
          r_v[5]  <= r_v[4];
          r_v[6]  <= r_v[5];
          r_v[7]  <= r_v[6];
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
          r_ptr <= '0;
        end
        ST_OUTPUT: begin
          if (dig_ready) begin
            if (w_dlast) begin
              r_obeat     <= '0;
              r_busy      <= 1'b0;
              r_len       <= '0;
              r_ptr       <= '0;
              r_last_seen <= 1'b0;
              r_pad_done  <= 1'b0;
              r_final     <= 1'b0;
              for (int i = 0; i < 8; i++) r_h[i] <= IV_256[255-32*i -: 32];
            end else begin
              r_obeat <= r_obeat + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dig_data = '0;
    if (r_state == ST_OUTPUT) begin
      for (int i = 0; i < N256; i++) begin
        if (r_obeat == 6'(i)) dig_data = w_hcat[255-i*OUT_W -: OUT_W];
      end
    end
  end

endmodule

// File: doc/sha2_stream_core.md
# sha2_stream_core

Parametrised streaming SHA-256/SHA-224 engine that absorbs arbitrary-length messages over a valid/ready byte-lane bus, performs full hardware padding (including the extra padding block), chains multiple 512-bit blocks, and streams the digest out over a second valid/ready bus. It replaces the fixed 8-bit, single-block hasher as the hash core behind the TinyTapeout pin wrapper; one round per clock, rolling 16-word message schedule.

## Interface
- IN_W, 8, input beat width in bits; legal 8, 16, 32 (other values: elaboration error)
- OUT_W, 8, digest beat width in bits; legal 8, 16, 32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  IN_W  message bytes, first byte in MSBs (big-endian within beat)
- in_valid  in  1  beat valid
- in_last  in  1  beat is final beat of message
- in_nbytes  in  3  valid bytes in final beat, 0..IN_W/8, left-justified; ignored when in_last=0
- mode_224  in  1  1 = SHA-224, 0 = SHA-256; sampled on first accepted beat of a message
- in_ready  out  1  beat accepted on edge where in_valid & in_ready
- dig_data  out  OUT_W  digest beat, H0 MSB first
- dig_valid  out  1  digest beat valid
- dig_last  out  1  final digest beat
- dig_ready  in  1  digest beat consumed on edge where dig_valid & dig_ready
- busy  out  1  message in progress

## Operation
- States: ABSORB, PAD, COMPRESS, UPDATE, OUTPUT.
- ABSORB: in_ready=1. Accepted bytes packed big-endian into 16-word block buffer; byte pointer 0..64; 64-bit bit-length counter += 8 per byte (wraps mod 2^64). in_nbytes > IN_W/8 clamped to IN_W/8. Beats never straddle blocks (IN_W divides 512).
- Block full (pointer reaches 64) without in_last -> COMPRESS, then back to ABSORB with pointer 0.
- Block full with in_last on same beat -> COMPRESS, then PAD with empty block.
- in_last with pointer < 64 after beat -> PAD.
- PAD (1 cycle): byte at pointer = 0x80, remaining bytes zero. If pointer <= 55: bytes 56..63 = length, big-endian, mark final. Else mark pad-only, compress, re-enter PAD with zero block + length.
- COMPRESS: 64 cycles, round index 0..63; K from 64-entry constant ROM; W_t from rolling 16-word shift register (t>=16: W_t = s1(W_t-2)+W_t-7+s0(W_t-15)+W_t-16, mod 2^32).
- UPDATE (1 cycle): H_i += working var, mod 2^32. If final -> OUTPUT else ABSORB/PAD per above.
- IV loaded at reset and after final digest beat: SHA-256 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; SHA-224 c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4 (selected at first beat).
- OUTPUT: 256/OUT_W beats (SHA-256) or 224/OUT_W beats (SHA-224, H7 dropped). dig_data/dig_last stable while dig_valid & !dig_ready. After last beat accepted: IV reload, ABSORB.
- Empty message: first beat in_last=1, in_nbytes=0 -> PAD at pointer 0.
- busy: 1 from first accepted beat to acceptance of dig_last beat.
- mode_224 changes mid-message ignored.

## Timing
- Reset values: in_ready=1 (decoded from ABSORB), dig_valid=0, dig_last=0, dig_data=0, busy=0; pointer, length, round cleared; H = SHA-256 IV.
- Reset mid-operation: message discarded, all of above immediately; no digest emitted.
- in_ready=0 throughout PAD, COMPRESS, UPDATE, OUTPUT.
- Full non-final block: 65 cycles in_ready low (64 rounds + update).
- Latency, last-beat edge E0 to dig_valid high: pointer<=55 -> E0+66; 56..63 -> E0+132; 64 -> E0+131.
- Output at full throughput: one beat per cycle; in_ready=1 the cycle after dig_last accepted.

## Test plan
- "abc", IN_W=8, OUT_W=32, SHA-256 -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, dig_valid at E0+66, dig_last on beat 8.
- Empty message (in_last, in_nbytes=0) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", IN_W=32, last in_nbytes=4 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1 at E0+132.
- "abc", mode_224=1, OUT_W=8 -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, 28 beats, dig_last on 28th.
- Random dig_ready stalls and in_valid gaps on "abc" with IN_W=16 (last in_nbytes=1) -> identical digest, dig_data stable under stall.
- rst_n low during COMPRESS of the 56-byte message, then "abc" -> no digest from first, correct "abc" digest.
